// File: rtl/scs8hd_dlrtn_rf_if.sv
// ----------------------------------------------------------------------------
// scs8hd_dlrtn_rf_if
// Write/read bus of the latch register file.
//
// Handshake: a write transfer happens on a rising CLK edge where WVALID and
// WREADY are both 1. The master holds WADDR/WDATA/WMASK stable while WVALID
// is 1 and WREADY is 0. The slave never makes WREADY depend on WVALID.
//
// Signals:
//   WVALID  master->slave  write request
//   WREADY  slave->master  write accept
//   WADDR   master->slave  write entry index (AW bits)
//   WDATA   master->slave  write data (WIDTH bits)
//   WMASK   master->slave  per-bit write enable (1 = bit updated)
//   RADDR   master->slave  read entry index (AW bits)
//   RDATA   slave->master  registered read data
//   ERR     slave->master  sticky out-of-range flag
//   ERR_CLR master->slave  synchronous clear of ERR
// ----------------------------------------------------------------------------
interface scs8hd_dlrtn_rf_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) ();
  logic             WVALID;
  logic             WREADY;
  logic [AW-1:0]    WADDR;
  logic [WIDTH-1:0] WDATA;
  logic [WIDTH-1:0] WMASK;
  logic [AW-1:0]    RADDR;
  logic [WIDTH-1:0] RDATA;
  logic             ERR;
  logic             ERR_CLR;

  modport master (
    output WVALID, WADDR, WDATA, WMASK, RADDR, ERR_CLR,
    input  WREADY, RDATA, ERR
  );

  modport slave (
    input  WVALID, WADDR, WDATA, WMASK, RADDR, ERR_CLR,
    output WREADY, RDATA, ERR
  );
endinterface

// File: rtl/scs8hd_dlrtn_rf.sv
// ----------------------------------------------------------------------------
// scs8hd_dlrtn_rf
// Latch-based register file: DEPTH entries x WIDTH bits of active-low-gate,
// active-low-reset latches. A two-state write controller (IDLE/OPEN) turns an
// accepted write into a one-cycle active-low gate pulse on the addressed entry.
// Reads are registered, with a bypass of the staged data while OPEN.
//
// Ports:
//   CLK        rising-edge clock
//   RESETB     asynchronous active-low reset
//   bus        slave side of scs8hd_dlrtn_rf_if (write handshake, read, ERR)
//   DBG_STATE  current write FSM state (0 = IDLE, 1 = OPEN)
// ----------------------------------------------------------------------------
module scs8hd_dlrtn_rf #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RESETB,
  scs8hd_dlrtn_rf_if.slave  bus,
  output logic              DBG_STATE
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       rst_sync;
  logic             rst_ok;
  logic [DEPTH-1:0] gate_n, gate_n_nxt;
  logic [AW-1:0]    stage_addr, stage_addr_nxt;
  logic [WIDTH-1:0] stage_data, stage_data_nxt;
  logic [WIDTH-1:0] rdata_q, rdata_nxt;
  logic             err_q;
  logic             wready;
  logic             wr_accept;
  logic             waddr_bad;
  logic             raddr_bad;
  logic [WIDTH-1:0] wr_entry;
  logic [WIDTH-1:0] rd_entry;
  logic [DEPTH*WIDTH-1:0] mem_flat;

  // Reset release is synchronised so WREADY never rises near a RESETB edge.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_ok = rst_sync[1];

  // --------------------------------------------------------------------------
  // Latch storage. Reset dominates the gate, so an entry that is open when
  // RESETB falls is forced to RESET_VAL immediately.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [WIDTH-1:0] q;
    always_latch begin
      if (!RESETB)        q <= RESET_VAL;
      else if (!gate_n[g]) q <= stage_data;
    end
    assign mem_flat[g*WIDTH +: WIDTH] = q;
  end

  // Entry selection for the write merge and the read port. Out-of-range
  // indices select nothing (zero).
  always_comb begin
    wr_entry = '0;
    rd_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.WADDR == AW'(i)) wr_entry = mem_flat[i*WIDTH +: WIDTH];
      if (bus.RADDR == AW'(i)) rd_entry = mem_flat[i*WIDTH +: WIDTH];
    end
  end

  assign waddr_bad = {1'b0, bus.WADDR} >= DEPTH_W;
  assign raddr_bad = {1'b0, bus.RADDR} >= DEPTH_W;
  assign wready    = (state == IDLE) && rst_ok;
  assign wr_accept = bus.WVALID && wready;

  // --------------------------------------------------------------------------
  // Write FSM. gate_n is registered from a one-hot decode so the latch gates
  // have no combinational path from CLK or inputs. Staging registers load only
  // on accept, so they hold steady through the whole OPEN cycle and beyond the
  // closing edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= IDLE;
      gate_n     <= '1;
      stage_addr <= '0;
      stage_data <= '0;
    end else begin
      state      <= state_nxt;
      gate_n     <= gate_n_nxt;
      stage_addr <= stage_addr_nxt;
      stage_data <= stage_data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gate_n_nxt     = '1;
    stage_addr_nxt = stage_addr;
    stage_data_nxt = stage_data;
    case (state)
      IDLE: begin
        if (wr_accept && !waddr_bad) begin
          state_nxt      = OPEN;
          stage_addr_nxt = bus.WADDR;
          stage_data_nxt = (bus.WDATA & bus.WMASK) | (wr_entry & ~bus.WMASK);
          for (int i = 0; i < DEPTH; i++) begin
            if (bus.WADDR == AW'(i)) gate_n_nxt[i] = 1'b0;
          end
        end
      end
      OPEN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read port and sticky error flag.
  // --------------------------------------------------------------------------
  always_comb begin
    rdata_nxt = rd_entry;
    if (raddr_bad)
      rdata_nxt = '0;
    else if (state == OPEN && bus.RADDR == stage_addr)
      rdata_nxt = stage_data;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_nxt;
      // A new error beats a simultaneous clear.
      if ((wr_accept && waddr_bad) || raddr_bad) err_q <= 1'b1;
      else if (bus.ERR_CLR)                      err_q <= 1'b0;
    end
  end

  assign bus.WREADY = wready;
  assign bus.RDATA  = rdata_q;
  assign bus.ERR    = err_q;
  assign DBG_STATE  = (state == OPEN);

endmodule
